// File: rtl/count_burst_arbiter.sv
// Round-robin arbiter sharing one AXI-stream count generator among four requesters.
// Each grant emits data 0..len tagged with the requester ID, then pulses that requester's done bit.
module count_burst_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned LW   = 5
) (
    input  logic                 counter_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LW-1:0]   req_len,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [DW-1:0]        m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [1:0]           m_axis_tid
);

    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] tid_q, tid_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;

    logic          win_valid;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          last_beat;

    // First requesting index at or above rr_ptr, wrapping to 0.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(rr_ptr_q) + i) % NREQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        tid_d    = tid_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (enable && win_valid) begin
                    tid_d   = win_idx;
                    len_d   = req_len[win_idx*LW +: LW];
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (m_axis_tready) begin
                    if (last_beat) begin
                        state_d  = StDone;
                        rr_ptr_d = IW'((32'(tid_q) + 1) % NREQ);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                // No arbitration here so a requester can drop req on seeing done.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge counter_clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            tid_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            tid_q    <= tid_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        grant = '0;
        done  = '0;
        if (state_q == StBurst) grant[tid_q] = 1'b1;
        if (state_q == StDone)  done[tid_q]  = 1'b1;
    end

    assign busy          = (state_q != StIdle);
    assign m_axis_tvalid = (state_q == StBurst);
    assign m_axis_tlast  = (state_q == StBurst) && last_beat;
    assign m_axis_tdata  = DW'(cnt_q);
    assign m_axis_tid    = 2'(tid_q);

endmodule

// File: tb/tb_count_burst_arbiter.sv
// Directed bench for count_burst_arbiter: ordering, lengths, backpressure, enable/req drop, reset.
module tb_count_burst_arbiter;

    logic        counter_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [19:0] req_len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [1:0]  m_axis_tid;

    int checks = 0;
    int errors = 0;

    count_burst_arbiter dut (
        .counter_clk   (counter_clk),
        .reset         (reset),
        .enable        (enable),
        .req           (req),
        .req_len       (req_len),
        .grant         (grant),
        .done          (done),
        .busy          (busy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid)
    );

    always #5 counter_clk = ~counter_clk;

    task automatic tick();
        @(posedge counter_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int idx, input int val);
        req_len[5*idx +: 5] = 5'(val);
    endtask

    // Entered on the first BURST cycle with tready=1; returns in IDLE after DONE.
    task automatic run_burst(input int exp_tid, input int len);
        for (int b = 0; b <= len; b++) begin
            check("tvalid", 32'(m_axis_tvalid), 32'd1);
            check("tdata", m_axis_tdata, 32'(b));
            check("tlast", 32'(m_axis_tlast), 32'(b == len));
            check("tid", 32'(m_axis_tid), 32'(exp_tid));
            check("grant", 32'(grant), 32'(1) << exp_tid);
            tick();
        end
        check("done_pulse", 32'(done), 32'(1) << exp_tid);
        check("done_grant", 32'(grant), 32'd0);
        check("done_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
        check({tag, "_tdata"}, m_axis_tdata, 32'd0);
        check({tag, "_tid"}, 32'(m_axis_tid), 32'd0);
    endtask

    initial begin
        int exp_cnt;
        int beats;
        int cycles;
        bit fin;
        logic r;

        reset         = 1'b1;
        enable        = 1'b0;
        req           = 4'b0000;
        req_len       = '0;
        m_axis_tready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("rst");

        // Single requester, length 3, req held across two bursts.
        enable        = 1'b1;
        req           = 4'b0001;
        set_len(0, 3);
        m_axis_tready = 1'b1;
        tick();
        run_burst(0, 3);
        tick();
        check("regrant_tvalid", 32'(m_axis_tvalid), 32'd1);
        req = 4'b0000;
        run_burst(0, 3);

        // Fairness from reset with all requesters and zero lengths.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        req_len = '0;
        req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            run_burst(k % 4, 0);
        end

        // Length boundaries on requester 2.
        req = 4'b0100;
        set_len(2, 0);
        tick();
        run_burst(2, 0);
        set_len(2, 31);
        tick();
        run_burst(2, 31);

        // Random backpressure during an 8-beat burst on requester 1.
        req = 4'b0010;
        set_len(1, 7);
        tick();
        req     = 4'b0000;
        exp_cnt = 0;
        beats   = 0;
        cycles  = 0;
        fin     = 1'b0;
        while (!fin && cycles < 200) begin
            check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("bp_tdata", m_axis_tdata, 32'(exp_cnt));
            check("bp_tlast", 32'(m_axis_tlast), 32'(exp_cnt == 7));
            check("bp_tid", 32'(m_axis_tid), 32'd1);
            r             = 1'($urandom_range(0, 1));
            m_axis_tready = r;
            tick();
            cycles++;
            if (r) begin
                beats++;
                if (exp_cnt == 7) fin = 1'b1;
                else exp_cnt++;
            end
        end
        check("bp_finished", 32'(fin), 32'd1);
        check("bp_beats", 32'(beats), 32'd8);
        check("bp_done", 32'(done), 32'b0010);
        m_axis_tready = 1'b1;
        tick();

        // Enable dropped mid-burst: burst completes, no new grant while low.
        req = 4'b0001;
        set_len(0, 3);
        tick();
        enable = 1'b0;
        run_burst(0, 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("noen_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("noen_grant", 32'(grant), 32'd0);
            check("noen_busy", 32'(busy), 32'd0);
        end
        enable = 1'b1;
        tick();
        check("reen_grant", 32'(grant), 32'b0001);
        // Req dropped mid-burst: burst still completes.
        req = 4'b0000;
        run_burst(0, 3);
        tick();
        check("noreq_busy", 32'(busy), 32'd0);

        // Reset on beat 2 of a 6-beat burst on requester 3.
        req = 4'b1000;
        set_len(3, 5);
        tick();
        check("rb_tid", 32'(m_axis_tid), 32'd3);
        req = 4'b0000;
        tick();
        tick();
        check("rb_beat2", m_axis_tdata, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("midrst");
        // rr_ptr back at 0 picks requester 0 over 3.
        set_len(0, 1);
        req = 4'b1001;
        tick();
        req = 4'b0000;
        run_burst(0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
